rgb_led_pwm: RTL and testbench

RGB_LED_PWM -- requirements
Module: rgb_led_pwm

---
 rtl/rgb_led_pwm.sv | 115 +++++++++++
 tb/tb_rgb_led_pwm.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_pwm.sv
// rtl/rgb_led_pwm.sv - multi-channel RGB LED PWM driver with static, blink and breathe modes
// Red/green come from the SoC LED word; blue lights where both are set.
module rgb_led_pwm #(
   parameter int NCH     = 4,
   parameter int PWM_W   = 8,
   parameter int DIV     = 1000,
   parameter int BLINK_W = 6
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               en,
   input  logic [1:0]         mode,
   input  logic [PWM_W-1:0]   bright,
   input  logic [2*NCH-1:0]   src,
   output logic [NCH-1:0]     led_r,
   output logic [NCH-1:0]     led_g,
   output logic [NCH-1:0]     led_b,
   output logic               frame
);

   localparam int PRE_W = $clog2(DIV) + 1;
   localparam logic [PRE_W-1:0] DIV_M1  = PRE_W'(DIV - 1);
   localparam logic [PWM_W-1:0] PWM_MAX = '1;

   typedef enum logic {RAMP_DOWN = 1'b0, RAMP_UP = 1'b1} ramp_dir_t;

   logic [PRE_W-1:0]   pre;
   logic [PWM_W-1:0]   pwm_cnt;
   logic [PWM_W-1:0]   duty_q;
   logic [PWM_W-1:0]   duty_nxt;
   logic [BLINK_W-1:0] frame_cnt;
   logic               blink_ph;
   logic [PWM_W-1:0]   ramp;
   ramp_dir_t          dir;
   logic [2*NCH-1:0]   src_q;
   logic [NCH-1:0]     src_r;
   logic [NCH-1:0]     src_g;
   logic               tick;
   logic               wrap;
   logic               on;

   for (genvar i = 0; i < NCH; i++) begin : g_split
      assign src_r[i] = src_q[2*i];
      assign src_g[i] = src_q[2*i+1];
   end

   assign tick = en && (pre == DIV_M1);
   assign wrap = tick && (pwm_cnt == PWM_MAX);
   assign on   = (pwm_cnt < duty_q);

   always_comb begin
      duty_nxt = '0;
      case (mode)
         2'd0:    duty_nxt = bright;
         2'd1:    duty_nxt = blink_ph ? bright : '0;
         2'd2:    duty_nxt = ramp;
         default: duty_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pre       <= '0;
         pwm_cnt   <= '0;
         duty_q    <= '0;
         frame_cnt <= '0;
         blink_ph  <= 1'b0;
         ramp      <= '0;
         dir       <= RAMP_UP;
         src_q     <= '0;
         led_r     <= '0;
         led_g     <= '0;
         led_b     <= '0;
         frame     <= 1'b0;
      end else begin
         src_q <= src;
         frame <= wrap;
         if (en) begin
            pre <= tick ? '0 : pre + PRE_W'(1);
            if (tick)
               pwm_cnt <= pwm_cnt + PWM_W'(1);
            // Duty and the effect counters only move at the period boundary
            if (wrap) begin
               duty_q    <= duty_nxt;
               frame_cnt <= frame_cnt + BLINK_W'(1);
               if (frame_cnt == '1)
                  blink_ph <= ~blink_ph;
               if (dir == RAMP_UP) begin
                  if (ramp == PWM_MAX) begin
                     dir  <= RAMP_DOWN;
                     ramp <= ramp - PWM_W'(1);
                  end else begin
                     ramp <= ramp + PWM_W'(1);
                  end
               end else begin
                  if (ramp == '0) begin
                     dir  <= RAMP_UP;
                     ramp <= ramp + PWM_W'(1);
                  end else begin
                     ramp <= ramp - PWM_W'(1);
                  end
               end
            end
            led_r <= src_r & {NCH{on}};
            led_g <= src_g & {NCH{on}};
            led_b <= src_r & src_g & {NCH{on}};
         end else begin
            led_r <= '0;
            led_g <= '0;
            led_b <= '0;
         end
      end
   end

endmodule

// File: tb/tb_rgb_led_pwm.sv
// tb/tb_rgb_led_pwm.sv - scoreboard bench for rgb_led_pwm
// Each PWM period is checked at its frame pulse: per-LED on-counts, period length, no drive while paused.
module tb_rgb_led_pwm;

   localparam int NCH     = 4;
   localparam int PWM_W   = 4;
   localparam int DIV     = 1;
   localparam int BLINK_W = 2;

   logic             clk = 1'b0;
   logic             resetn;
   logic             en;
   logic [1:0]       mode;
   logic [PWM_W-1:0] bright;
   logic [2*NCH-1:0] src;
   logic [NCH-1:0]   led_r;
   logic [NCH-1:0]   led_g;
   logic [NCH-1:0]   led_b;
   logic             frame;

   always #5 clk = ~clk;

   rgb_led_pwm #(
      .NCH     (NCH),
      .PWM_W   (PWM_W),
      .DIV     (DIV),
      .BLINK_W (BLINK_W)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .en     (en),
      .mode   (mode),
      .bright (bright),
      .src    (src),
      .led_r  (led_r),
      .led_g  (led_g),
      .led_b  (led_b),
      .frame  (frame)
   );

   typedef struct packed {
      logic [3:0][4:0] r;
      logic [3:0][4:0] g;
      logic [3:0][4:0] b;
      logic [7:0]      len;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_win  = 0;

   int blink_duty [13] = '{0, 0, 0, 0, 0, 8, 8, 8, 8, 0, 0, 0, 0};
   int breathe_duty [34] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                             14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

   function automatic exp_t mk(int duty, logic [7:0] s, int len);
      exp_t e;
      e = '0;
      for (int i = 0; i < NCH; i++) begin
         e.r[i] = s[2*i]   ? 5'(duty) : 5'd0;
         e.g[i] = s[2*i+1] ? 5'(duty) : 5'd0;
         e.b[i] = (s[2*i] && s[2*i+1]) ? 5'(duty) : 5'd0;
      end
      e.len = 8'(len);
      return e;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, req);
   endtask

   task automatic push(int duty, int len);
      exp_q.push_back(mk(duty, src, len));
   endtask

   task automatic do_reset(logic [1:0] m, logic [3:0] b, logic [7:0] s);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check("reset_outs", {led_r, led_g, led_b, frame}, 64'd0);
      en = 1'b0; mode = m; bright = b; src = s;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      en = 1'b1;
   endtask

   task automatic wait_frame(int limit);
      int c;
      c = 0;
      while (c < limit) begin
         @(posedge clk); #1;
         c++;
         if (frame) break;
      end
      check("wait_frame", 64'(frame), 64'd1);
   endtask

   task automatic drain(int limit);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < limit) begin
         @(posedge clk); #2;
         c++;
      end
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else begin
         $display("FAIL drain: %0d periods still pending, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: accumulates each period and scores it when frame pulses
   initial begin
      logic [3:0][4:0] ar, ag, ab;
      int   edges, leak;
      exp_t e;
      ar = '0; ag = '0; ab = '0; edges = 0; leak = 0;
      forever begin
         @(posedge clk); #1;
         if (!resetn) begin
            ar = '0; ag = '0; ab = '0; edges = 0; leak = 0;
         end else begin
            edges++;
            if (!en && (led_r != 0 || led_g != 0 || led_b != 0 || frame)) leak++;
            for (int i = 0; i < NCH; i++) begin
               ar[i] = ar[i] + 5'(led_r[i]);
               ag[i] = ag[i] + 5'(led_g[i]);
               ab[i] = ab[i] + 5'(led_b[i]);
            end
            if (frame) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_frame: frame at %0t, want none", $time);
               end else begin
                  e = exp_q.pop_front();
                  n_win++;
                  check($sformatf("win%0d_ontime", n_win), 64'({ar, ag, ab}), 64'({e.r, e.g, e.b}));
                  check($sformatf("win%0d_len", n_win), 64'(edges), 64'(e.len));
                  check($sformatf("win%0d_paused_drive", n_win), 64'(leak), 64'd0);
               end
               ar = '0; ag = '0; ab = '0; edges = 0; leak = 0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b1; en = 1'b0; mode = 2'd0; bright = '0; src = '0;
      #3 resetn = 1'b0;

      // static duty on red channel 0
      do_reset(2'd0, 4'd5, 8'h01);
      push(0, 16);
      repeat (3) push(5, 16);
      drain(200);

      // red+green on channel 3 gives blue too
      do_reset(2'd0, 4'd15, 8'hC0);
      push(0, 16);
      repeat (2) push(15, 16);
      drain(200);

      // bright change mid-period only lands at the next period
      do_reset(2'd0, 4'd5, 8'h01);
      push(0, 16); push(5, 16); push(5, 16); push(10, 16); push(10, 16);
      wait_frame(40);
      wait_frame(40);
      repeat (3) @(posedge clk);
      @(negedge clk);
      bright = 4'd10;
      drain(200);

      do_reset(2'd1, 4'd8, 8'h03);
      for (int k = 0; k < 13; k++) push(blink_duty[k], 16);
      drain(400);

      do_reset(2'd2, 4'd0, 8'h02);
      for (int k = 0; k < 34; k++) push(breathe_duty[k], 16);
      drain(700);

      // pause at pwm_cnt=7 for 20 cycles stretches the period to 36
      do_reset(2'd0, 4'd5, 8'h01);
      push(0, 16); push(5, 16); push(5, 36); push(5, 16);
      wait_frame(40);
      wait_frame(40);
      repeat (7) @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      repeat (20) @(negedge clk);
      en = 1'b1;
      drain(200);

      // reset mid-period while red is lit
      do_reset(2'd0, 4'd5, 8'h01);
      push(0, 16); push(5, 16);
      drain(200);
      repeat (2) @(posedge clk);
      #1;
      check("pre_reset_led_r", 64'(led_r), 64'h1);
      do_reset(2'd0, 4'd5, 8'h01);
      push(0, 16); push(5, 16);
      drain(200);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
